// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared types for the AHB master request/burst controller.
// Optional REQ-phase timeout is enabled with macro AHB_MST_REQ_TIMEOUT_EN.
package ahb_master_req_ctrl_pkg;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    // Index of the final beat; undefined-length INCR is issued as one beat.
    function automatic logic [3:0] burst_last_idx(hburst_type b);
        case (b)
            HB_WRAP4,  HB_INCR4:  return 4'd3;
            HB_WRAP8,  HB_INCR8:  return 4'd7;
            HB_WRAP16, HB_INCR16: return 4'd15;
            default:              return 4'd0;
        endcase
    endfunction

    function automatic logic burst_is_wrap(hburst_type b);
        return (b == HB_WRAP4) || (b == HB_WRAP8) || (b == HB_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// Command + AHB address-phase bundle for ahb_master_req_ctrl.
// err_timeout exists only when AHB_MST_REQ_TIMEOUT_EN is defined.
interface ahb_master_req_ctrl_if
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    hburst_type            cmd_burst;
    logic                  cmd_write;
    logic                  hgrant;
    logic                  hreq;
    htrans_type            htrans;
    logic [ADDR_WIDTH-1:0] haddr;
    hburst_type            hburst;
    logic                  hwrite;
    logic                  beat_ack;
    logic [3:0]            beat_idx;
    logic                  busy;
`ifdef AHB_MST_REQ_TIMEOUT_EN
    logic                  err_timeout;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant,
        output cmd_ready, hreq, htrans, haddr, hburst, hwrite,
               beat_ack, beat_idx, busy, err_timeout
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant,
        input  cmd_ready, hreq, htrans, haddr, hburst, hwrite,
               beat_ack, beat_idx, busy, err_timeout
    );
`else
    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant,
        output cmd_ready, hreq, htrans, haddr, hburst, hwrite,
               beat_ack, beat_idx, busy
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_write, hgrant,
        input  cmd_ready, hreq, htrans, haddr, hburst, hwrite,
               beat_ack, beat_idx, busy
    );
`endif
endinterface

// File: rtl/ahb_master_req_ctrl_addr_gen.sv
// Combinational next-beat address: linear increment for INCR bursts,
// wrap inside a beats*BYTES_PER_BEAT aligned window for WRAP bursts.
module ahb_mst_addr_gen
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  hburst_type            hburst_i,
    output logic [ADDR_WIDTH-1:0] haddr_nxt_o
);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] span_mask;

    // Upper bits above the wrap span stay fixed; lower bits roll over.
    always_comb begin
        incr      = haddr_i + ADDR_WIDTH'(BYTES_PER_BEAT);
        span_mask = ((ADDR_WIDTH'(burst_last_idx(hburst_i)) + ADDR_WIDTH'(1))
                     * ADDR_WIDTH'(BYTES_PER_BEAT)) - ADDR_WIDTH'(1);
        if (burst_is_wrap(hburst_i)) begin
            haddr_nxt_o = (haddr_i & ~span_mask) | (incr & span_mask);
        end else begin
            haddr_nxt_o = incr;
        end
    end
endmodule

// File: rtl/ahb_master_req_ctrl.sv
// AHB master request/burst controller: takes a burst command, requests the
// bus, then issues NONSEQ/SEQ address-phase beats until the burst is done.
// Define AHB_MST_REQ_TIMEOUT_EN to abort a request that is never granted.
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int BYTES_PER_BEAT = 4,
    parameter int REQ_TIMEOUT    = 64
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_master_req_ctrl_if.master bus
);
    // The wait counter is 8 bits wide.
    if (REQ_TIMEOUT < 1 || REQ_TIMEOUT > 256) begin : g_bad_timeout
        $error("REQ_TIMEOUT must be in 1..256");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d, haddr_nxt;
    hburst_type            hburst_q, hburst_d;
    logic                  hwrite_q, hwrite_d;
    logic [3:0]            beat_idx_q, beat_idx_d;
    logic [3:0]            last_idx_q, last_idx_d;
`ifdef AHB_MST_REQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(REQ_TIMEOUT - 1);
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;
`endif

    ahb_mst_addr_gen #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BYTES_PER_BEAT (BYTES_PER_BEAT)
    ) u_addr_gen (
        .haddr_i     (haddr_q),
        .hburst_i    (hburst_q),
        .haddr_nxt_o (haddr_nxt)
    );

    // Next-state and datapath update; stalls (hgrant=0) simply hold state.
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hburst_d   = hburst_q;
        hwrite_d   = hwrite_q;
        beat_idx_d = beat_idx_q;
        last_idx_d = last_idx_q;
`ifdef AHB_MST_REQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    haddr_d    = bus.cmd_addr;
                    hburst_d   = bus.cmd_burst;
                    hwrite_d   = bus.cmd_write;
                    last_idx_d = burst_last_idx(bus.cmd_burst);
                    beat_idx_d = 4'd0;
`ifdef AHB_MST_REQ_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Grant here only hands over the bus; no beat is taken yet.
                if (bus.hgrant) begin
                    state_d = ST_XFER;
                end
`ifdef AHB_MST_REQ_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_XFER: begin
                if (bus.hgrant) begin
                    if (beat_idx_q == last_idx_q) begin
                        state_d    = ST_IDLE;
                        beat_idx_d = 4'd0;
                    end else begin
                        beat_idx_d = beat_idx_q + 4'd1;
                        haddr_d    = haddr_nxt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            hburst_q   <= HB_SINGLE;
            hwrite_q   <= 1'b0;
            beat_idx_q <= 4'd0;
            last_idx_q <= 4'd0;
`ifdef AHB_MST_REQ_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hburst_q   <= hburst_d;
            hwrite_q   <= hwrite_d;
            beat_idx_q <= beat_idx_d;
            last_idx_q <= last_idx_d;
`ifdef AHB_MST_REQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.hreq      = (state_q != ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.htrans    = (state_q != ST_XFER)  ? HT_IDLE :
                           (beat_idx_q == 4'd0)  ? HT_NONSEQ : HT_SEQ;
    assign bus.haddr     = haddr_q;
    assign bus.hburst    = hburst_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.beat_idx  = beat_idx_q;
    assign bus.beat_ack  = (state_q == ST_XFER) && bus.hgrant;
`ifdef AHB_MST_REQ_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`endif

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Self-checking bench for ahb_master_req_ctrl: table of burst commands with a
// per-beat scoreboard, plus hand sequences for reset abort and the optional
// AHB_MST_REQ_TIMEOUT_EN timeout.
module tb_ahb_master_req_ctrl;
    import ahb_master_req_ctrl_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_master_req_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    ahb_master_req_ctrl #(
        .ADDR_WIDTH     (32),
        .BYTES_PER_BEAT (4),
        .REQ_TIMEOUT    (8)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    typedef struct {
        hburst_type  burst;
        logic [31:0] addr;
        logic        write;
        int          gmode;     // 0 steady, 1 toggle 1001, 2 grant after 2 cycles, 3 random
        logic        hold;      // keep cmd_valid high (with junk addr) while busy
        int          beats;
        logic [31:0] last;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  idx;
    } beat_t;

    beat_t       sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          beats_seen;
    logic [31:0] last_addr;
    logic        cur_write;
    hburst_type  cur_burst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(hburst_type b, logic [31:0] start, int i, int beats);
        logic [31:0] span, base;
        if (b == HB_WRAP4 || b == HB_WRAP8 || b == HB_WRAP16) begin
            span = 32'(beats * 4);
            base = start - (start % span);
            return base + ((start - base + 32'(i * 4)) % span);
        end
        return start + 32'(i * 4);
    endfunction

    function automatic logic grant_at(int mode, int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            2:       return c >= 2;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Per-cycle monitor: every address-phase cycle must match the scoreboard head.
    always @(negedge hclk) begin
        if (!hreset) begin
            chk("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
            if (bus.htrans != HT_IDLE) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("haddr", bus.haddr, sb_q[0].addr);
                    chk("beat_idx", bus.beat_idx, sb_q[0].idx);
                    chk("htrans", bus.htrans, (sb_q[0].idx == 0) ? HT_NONSEQ : HT_SEQ);
                    chk("hreq_xfer", bus.hreq, 1);
                    chk("hwrite", bus.hwrite, cur_write);
                    chk("hburst", bus.hburst, cur_burst);
                    if (bus.beat_ack) begin
                        last_addr = bus.haddr;
                        beats_seen++;
                        void'(sb_q.pop_front());
                    end
                end
            end else begin
                chk("beat_ack_idle", bus.beat_ack, 0);
            end
        end
    end

    // Issue one command from a driving point (#1 after posedge); returns at the same point.
    task automatic run_cmd(input vec_t v);
        int   c;
        logic done;
        for (int i = 0; i < v.beats; i++)
            sb_q.push_back('{addr: exp_addr(v.burst, v.addr, i, v.beats), idx: 4'(i)});
        beats_seen    = 0;
        cur_write     = v.write;
        cur_burst     = v.burst;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = v.addr;
        bus.cmd_burst = v.burst;
        bus.cmd_write = v.write;
        @(negedge hclk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge hclk); #1;
        bus.cmd_valid = v.hold;
        bus.cmd_addr  = 32'hDEAD_0000;
        bus.cmd_burst = HB_INCR16;
        done = 1'b0;
        c    = 0;
        while (!done && c < 300) begin
            bus.hgrant = grant_at(v.gmode, c);
            @(negedge hclk);
            if (!bus.busy) begin
                done = 1'b1;
                bus.cmd_valid = 1'b0;
            end else begin
                @(posedge hclk); #1;
                c++;
            end
        end
        bus.hgrant = 1'b0;
        chk("burst_done_in_bound", done, 1);
        chk("hreq_gap", bus.hreq, 0);
        chk("htrans_gap", bus.htrans, HT_IDLE);
        chk("beat_count", beats_seen, v.beats);
        chk("last_addr", last_addr, v.last);
        chk("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        @(posedge hclk); #1;
    endtask

    vec_t vecs[9];

    initial begin
        int c;
        vecs[0] = '{HB_SINGLE, 32'h0000_0100, 1'b1, 2, 1'b0, 1,  32'h0000_0100};
        vecs[1] = '{HB_INCR4,  32'h0000_1000, 1'b0, 0, 1'b0, 4,  32'h0000_100C};
        vecs[2] = '{HB_WRAP8,  32'h0000_2014, 1'b0, 0, 1'b0, 8,  32'h0000_2010};
        vecs[3] = '{HB_INCR16, 32'h0000_3000, 1'b1, 1, 1'b0, 16, 32'h0000_303C};
        vecs[4] = '{HB_WRAP4,  32'h0000_0038, 1'b1, 0, 1'b1, 4,  32'h0000_0034};
        vecs[5] = '{HB_INCR,   32'h0000_0044, 1'b0, 0, 1'b1, 1,  32'h0000_0044};
        vecs[6] = '{HB_WRAP16, 32'h0000_04F0, 1'b0, 1, 1'b0, 16, 32'h0000_04EC};
        vecs[7] = '{HB_INCR8,  32'hFFFF_FFF0, 1'b1, 0, 1'b0, 8,  32'h0000_000C};
        vecs[8] = '{HB_WRAP8,  32'h0000_0000, 1'b0, 3, 1'b0, 8,  32'h0000_001C};

        hreset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_burst = HB_SINGLE;
        bus.cmd_write = 1'b0;
        bus.hgrant    = 1'b0;
        cur_write     = 1'b0;
        cur_burst     = HB_SINGLE;
        last_addr     = '0;
        beats_seen    = 0;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;

        // Reset state
        @(negedge hclk);
        chk("rst_hreq", bus.hreq, 0);
        chk("rst_htrans", bus.htrans, HT_IDLE);
        chk("rst_haddr", bus.haddr, 0);
        chk("rst_hburst", bus.hburst, HB_SINGLE);
        chk("rst_hwrite", bus.hwrite, 0);
        chk("rst_beat_idx", bus.beat_idx, 0);
        chk("rst_beat_ack", bus.beat_ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
`ifdef AHB_MST_REQ_TIMEOUT_EN
        chk("rst_err_timeout", bus.err_timeout, 0);
`endif
        @(posedge hclk); #1;

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Reset during beat 2 of an INCR8 aborts with no drain
        for (int i = 0; i < 8; i++)
            sb_q.push_back('{addr: 32'h0000_5000 + 32'(i * 4), idx: 4'(i)});
        cur_write     = 1'b1;
        cur_burst     = HB_INCR8;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_5000;
        bus.cmd_burst = HB_INCR8;
        bus.cmd_write = 1'b1;
        @(posedge hclk); #1;
        bus.cmd_valid = 1'b0;
        bus.hgrant    = 1'b1;
        c = 0;
        while (c < 50) begin
            @(negedge hclk);
            if (bus.htrans != HT_IDLE && bus.beat_idx == 4'd2) break;
            c++;
        end
        chk("reach_beat2", (c < 50), 1);
        #1 hreset = 1'b1;
        @(negedge hclk);
        chk("abort_hreq", bus.hreq, 0);
        chk("abort_htrans", bus.htrans, HT_IDLE);
        chk("abort_beat_idx", bus.beat_idx, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_haddr", bus.haddr, 0);
        chk("abort_beat_ack", bus.beat_ack, 0);
        @(posedge hclk); #1;
        hreset     = 1'b0;
        bus.hgrant = 1'b0;
        sb_q.delete();
        @(posedge hclk); #1;

`ifdef AHB_MST_REQ_TIMEOUT_EN
        // No grant for 8 REQ cycles: abort with a one-cycle err_timeout
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_6000;
        bus.cmd_burst = HB_SINGLE;
        @(posedge hclk); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge hclk);
            chk("to_hreq_waiting", bus.hreq, 1);
            chk("to_err_early", bus.err_timeout, 0);
        end
        @(negedge hclk);
        chk("to_err_pulse", bus.err_timeout, 1);
        chk("to_hreq_drop", bus.hreq, 0);
        chk("to_idle", bus.busy, 0);
        @(negedge hclk);
        chk("to_err_one_cycle", bus.err_timeout, 0);
        @(posedge hclk); #1;

        // Grant on the 8th REQ cycle wins over expiry
        sb_q.push_back('{addr: 32'h0000_7000, idx: 4'd0});
        cur_write     = 1'b0;
        cur_burst     = HB_SINGLE;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_7000;
        bus.cmd_burst = HB_SINGLE;
        bus.cmd_write = 1'b0;
        @(posedge hclk); #1;
        bus.cmd_valid = 1'b0;
        repeat (7) @(posedge hclk);
        #1 bus.hgrant = 1'b1;
        @(negedge hclk);
        chk("late_grant_in_req", bus.htrans, HT_IDLE);
        @(negedge hclk);
        chk("late_grant_xfer", bus.htrans, HT_NONSEQ);
        chk("late_grant_no_err", bus.err_timeout, 0);
        @(posedge hclk); #1;
        bus.hgrant = 1'b0;
        @(negedge hclk);
        chk("late_grant_done", bus.busy, 0);
        chk("late_grant_no_err2", bus.err_timeout, 0);
        sb_q.delete();
`endif

        repeat (2) @(posedge hclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
Master-side request/burst controller: the initiator that drives the per-slave AHB arbiter.
- Accepts a burst command from local logic and raises hreq toward the arbiter.
- Waits for hgrant, then sequences NONSEQ/SEQ address-phase beats with correct incrementing or wrapping addresses.
- Drops hreq after the last beat is accepted.
- One instance sits between each bus master core and the interconnect.

Parameters:
ADDR_WIDTH, 32, haddr / cmd_addr width
BYTES_PER_BEAT, 4, address increment per beat (power of 2, 1..8)
REQ_TIMEOUT, 64, cycles in REQ without grant before abort (only with the optional feature)

Ports:
hclk  in  1  clock
hreset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  ADDR_WIDTH  start address, aligned to BYTES_PER_BEAT
cmd_burst  in  hburst_type  burst type
cmd_write  in  1  1 = write
hgrant  in  1  from arbiter; already includes ~hwait, 1 = beat accepted this cycle
hreq  out  1  request to arbiter
htrans  out  htrans_type  IDLE/NONSEQ/SEQ
haddr  out  ADDR_WIDTH  address-phase address
hburst  out  hburst_type  latched burst type
hwrite  out  1  latched direction
beat_ack  out  1  pulse: current beat accepted
beat_idx  out  4  index of the current beat (0..15)
busy  out  1  state != IDLE
err_timeout  out  1  only with the optional feature

Behaviour:
Reset (hreset=1 at posedge): state=IDLE, hreq=0, htrans=IDLE, haddr=0, hburst=SINGLE, hwrite=0, beat_idx=0, beat_ack=0, err_timeout=0. Reset mid-burst aborts immediately; there is no drain.

Beat count per burst type:
- SINGLE, INCR: 1 beat. INCR is treated as a single beat.
- WRAP4/INCR4: 4 beats.
- WRAP8/INCR8: 8 beats.
- WRAP16/INCR16: 16 beats.
- last_idx = beats-1, held in a 4-bit register.

FSM states are IDLE, REQ, XFER.
- IDLE:
  - cmd_ready=1, hreq=0, htrans=IDLE.
  - On cmd_valid: latch addr/burst/write, beat_idx=0, go to REQ.
- REQ:
  - hreq=1, htrans=IDLE, cmd_ready=0.
  - On hgrant=1: go to XFER. Grant seen in REQ does not count as a beat.
- XFER:
  - hreq=1, htrans=NONSEQ when beat_idx=0, otherwise SEQ.
  - hgrant=1: beat accepted. beat_ack=1 combinationally in that cycle.
  - Accepted beat with beat_idx<last_idx: beat_idx+1, haddr advances next cycle.
  - Accepted beat with beat_idx==last_idx: go to IDLE. hreq=0 and htrans=IDLE from the next cycle.
  - hgrant=0: stall. haddr/htrans/beat_idx hold, hreq stays 1.

Address rules:
- INCR types: haddr += BYTES_PER_BEAT, modulo 2^ADDR_WIDTH, no 1KB check.
- WRAP types: the wrap span is beats*BYTES_PER_BEAT. Upper bits are fixed and lower log2(span) bits increment modulo span.
- Example: WRAP4, BYTES_PER_BEAT=4, start 0x38 → 0x38, 0x3C, 0x30, 0x34.

Other boundary rules:
- cmd_valid while busy is ignored (cmd_ready=0).
- Back-to-back commands: after the last beat there is at least one IDLE cycle with hreq=0, so the arbiter can re-arbitrate.

Optional Feature:
Macro AHB_MST_REQ_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on REQ entry and increments each REQ cycle without hgrant.
  - When it reaches REQ_TIMEOUT-1 without grant: next state IDLE, hreq drops, err_timeout pulses 1 cycle.
  - Grant in the same cycle as expiry wins: go to XFER, no error.
- Not defined: the err_timeout port and counter are absent, and REQ waits indefinitely.

Decomposition:
- AHB_package: reuse hburst_type; add htrans_type (IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11) and a function burst_last_idx(hburst_type) returning a 4-bit value.
- Sub-module ahb_mst_addr_gen (combinational next-address from haddr, hburst, BYTES_PER_BEAT).
- FSM, counters and output registers stay in ahb_master_req_ctrl.

Test Plan:
- SINGLE write 0x100, hgrant high 2 cycles after hreq → exactly one NONSEQ beat at 0x100, beat_ack once, hreq low next cycle, busy low.
- INCR4 read 0x1000, hgrant steady 1 → NONSEQ 0x1000, then SEQ 0x1004, 0x1008, 0x100C; beat_idx 0..3; hreq drops after beat 3.
- WRAP8 at 0x2014 → addresses 0x2014, 18, 1C, 00, 04, 08, 0C, 10 (in 0x2000 block).
- INCR16 with hgrant toggled 1,0,0,1 pattern → haddr/beat_idx frozen during low cycles; 16 beat_acks total; no duplicated or skipped address.
- Assert hreset in XFER at beat 2 of INCR8 → next cycle hreq=0, htrans=IDLE, beat_idx=0, cmd_ready=1.
- With AHB_MST_REQ_TIMEOUT_EN, REQ_TIMEOUT=8, hgrant held 0 → err_timeout pulse after 8 REQ cycles, hreq 0, state IDLE.
- Same setup with hgrant on the 8th cycle → XFER entered, no err_timeout.
